// File: rtl/seq_alu_if.sv
// Request/response bus of the sequential ALU: operands and opcode in, result and flags out.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/negate/logic ops, iterative shift-add
// multiply and restoring-division modulo, valid/ready handshake on both sides.
module seq_alu #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;
    typedef enum logic [2:0] {
        OP_NEGA = 3'b000, OP_NEGB = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
        OP_AND  = 3'b100, OP_OR   = 3'b101, OP_MUL = 3'b110, OP_MOD = 3'b111
    } opT;

    stateT            state, stateNext;
    opT               opReg, opIn;
    logic [WIDTH-1:0] opA, opB;
    logic [WIDTH-1:0] accHi, accLo;
    logic [CNT_W-1:0] stepCnt;
    logic [WIDTH-1:0] resultReg;
    logic             carryReg, zeroReg, errReg;

    logic             fire, lastStep, goBusy;
    logic [WIDTH-1:0] addX, addY;
    logic             addCin;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] quickRes;
    logic             quickCarry, quickErr;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHiNext, mulLoNext;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH-1:0] divDiff, divRemNext;

    assign opIn     = opT'(bus.op);
    assign fire     = bus.in_valid && (state == IDLE);
    assign lastStep = (stepCnt == CNT_W'(WIDTH - 1));
    assign goBusy   = ((opIn == OP_MUL) && MUL_EN) || ((opIn == OP_MOD) && (bus.b != '0));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = resultReg;
    assign bus.carry     = carryReg;
    assign bus.zero      = zeroReg;
    assign bus.err       = errReg;

    // Single-cycle results, computed straight from the bus for the accepting cycle
    always_comb begin
        addX       = bus.a;
        addY       = bus.b;
        addCin     = 1'b0;
        quickRes   = '0;
        quickCarry = 1'b0;
        quickErr   = 1'b0;
        case (opIn)
            OP_NEGA: begin addX = ~bus.a; addY = '0;     addCin = 1'b1; end
            OP_NEGB: begin addX = ~bus.b; addY = '0;     addCin = 1'b1; end
            OP_SUB:  begin addX = bus.a;  addY = ~bus.b; addCin = 1'b1; end
            default: ;
        endcase
        addSum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
        case (opIn)
            OP_NEGA, OP_NEGB, OP_ADD, OP_SUB: begin
                quickRes   = addSum[WIDTH-1:0];
                quickCarry = addSum[WIDTH];
            end
            OP_AND: quickRes = bus.a & bus.b;
            OP_OR:  quickRes = bus.a | bus.b;
            OP_MUL: quickErr = 1'b1;
            OP_MOD: begin
                quickRes = bus.a;
                quickErr = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration step of multiply (shift-add) and modulo (restoring division)
    always_comb begin
        mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
        mulHiNext  = mulSum[WIDTH:1];
        mulLoNext  = {mulSum[0], accLo[WIDTH-1:1]};
        divTrial   = {accHi, accLo[WIDTH-1]};
        divDiff    = divTrial[WIDTH-1:0] - opB;
        divRemNext = (divTrial >= {1'b0, opB}) ? divDiff : divTrial[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fire) stateNext = goBusy ? BUSY : DONE;
            BUSY:    if (lastStep) stateNext = DONE;
            DONE:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA       <= '0;
            opB       <= '0;
            opReg     <= OP_NEGA;
            accHi     <= '0;
            accLo     <= '0;
            stepCnt   <= '0;
            resultReg <= '0;
            carryReg  <= 1'b0;
            zeroReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    opA     <= bus.a;
                    opB     <= bus.b;
                    opReg   <= opIn;
                    accHi   <= '0;
                    accLo   <= (opIn == OP_MUL) ? bus.b : bus.a;
                    stepCnt <= '0;
                    if (!goBusy) begin
                        resultReg <= quickRes;
                        carryReg  <= quickCarry;
                        zeroReg   <= (quickRes == '0);
                        errReg    <= quickErr;
                    end
                end
                BUSY: begin
                    stepCnt <= stepCnt + CNT_W'(1);
                    if (opReg == OP_MUL) begin
                        accHi <= mulHiNext;
                        accLo <= mulLoNext;
                        if (lastStep) begin
                            resultReg <= mulLoNext;
                            carryReg  <= |mulHiNext;
                            zeroReg   <= (mulLoNext == '0);
                            errReg    <= 1'b0;
                        end
                    end else begin
                        // accLo shifts dividend bits out MSB-first; quotient is not kept
                        accHi <= divRemNext;
                        accLo <= {accLo[WIDTH-2:0], 1'b0};
                        if (lastStep) begin
                            resultReg <= divRemNext;
                            carryReg  <= 1'b0;
                            zeroReg   <= (divRemNext == '0);
                            errReg    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8) plus a MUL_EN=0 instance.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(8)) bus ();
    seq_alu_if #(.WIDTH(8)) busNoMul ();

    seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    seq_alu #(.WIDTH(8), .MUL_EN(1'b0)) dutNoMul (.clk(clk), .reset(reset), .bus(busNoMul));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the main DUT; returns cycles from transfer to out_valid
    task automatic runOp(input logic [2:0] opc, input logic [7:0] aa, input logic [7:0] bb,
                         output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkVal("ready_wait", guard < 50, 1);
        bus.in_valid = 1'b1;
        bus.op = opc;
        bus.a = aa;
        bus.b = bb;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = ~opc;
        bus.a = ~aa;
        bus.b = ~bb;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkVal("ack_in_ready", bus.in_ready, 1);
        checkVal("ack_out_valid", bus.out_valid, 0);
    endtask

    task automatic doCheck(input string tag, input logic [2:0] opc, input logic [7:0] aa,
                           input logic [7:0] bb, input int expLat, input logic [7:0] res,
                           input logic c, input logic z, input logic e);
        int lat;
        runOp(opc, aa, bb, lat);
        checkVal($sformatf("%s_lat", tag), lat, expLat);
        checkVal($sformatf("%s_res", tag), bus.result, res);
        checkVal($sformatf("%s_carry", tag), bus.carry, c);
        checkVal($sformatf("%s_zero", tag), bus.zero, z);
        checkVal($sformatf("%s_err", tag), bus.err, e);
        ack();
    endtask

    task automatic noMulOp(input string tag, input logic [2:0] opc, input logic [7:0] aa,
                           input logic [7:0] bb, input logic [7:0] res, input logic z,
                           input logic e);
        busNoMul.in_valid = 1'b1;
        busNoMul.op = opc;
        busNoMul.a = aa;
        busNoMul.b = bb;
        @(posedge clk); #1;
        busNoMul.in_valid = 1'b0;
        checkVal($sformatf("%s_valid", tag), busNoMul.out_valid, 1);
        checkVal($sformatf("%s_res", tag), busNoMul.result, res);
        checkVal($sformatf("%s_carry", tag), busNoMul.carry, 0);
        checkVal($sformatf("%s_zero", tag), busNoMul.zero, z);
        checkVal($sformatf("%s_err", tag), busNoMul.err, e);
        busNoMul.out_ready = 1'b1;
        @(posedge clk); #1;
        busNoMul.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        bus.in_valid = 1'b1;
        bus.op = 3'b010;
        bus.a = 8'd1;
        bus.b = 8'd1;
        bus.out_ready = 1'b0;
        busNoMul.in_valid = 1'b0;
        busNoMul.op = 3'b000;
        busNoMul.a = '0;
        busNoMul.b = '0;
        busNoMul.out_ready = 1'b0;

        // Reset state, with in_valid held high during reset
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_out_valid", bus.out_valid, 0);
        checkVal("rst_result", bus.result, 0);
        checkVal("rst_carry", bus.carry, 0);
        checkVal("rst_zero", bus.zero, 0);
        checkVal("rst_err", bus.err, 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checkVal("rst_in_ready", bus.in_ready, 1);
        checkVal("rst_no_accept", bus.out_valid, 0);

        // Single-cycle ops
        doCheck("add_200_100", 3'b010, 8'd200, 8'd100, 1, 8'd44,  1'b1, 1'b0, 1'b0);
        doCheck("sub_5_5",     3'b011, 8'd5,   8'd5,   1, 8'd0,   1'b1, 1'b1, 1'b0);
        doCheck("nega_1",      3'b000, 8'd1,   8'd9,   1, 8'd255, 1'b0, 1'b0, 1'b0);
        doCheck("nega_0",      3'b000, 8'd0,   8'd9,   1, 8'd0,   1'b1, 1'b1, 1'b0);
        doCheck("negb_3",      3'b001, 8'd7,   8'd3,   1, 8'd253, 1'b0, 1'b0, 1'b0);
        doCheck("sub_3_5",     3'b011, 8'd3,   8'd5,   1, 8'd254, 1'b0, 1'b0, 1'b0);
        doCheck("add_0_0",     3'b010, 8'd0,   8'd0,   1, 8'd0,   1'b0, 1'b1, 1'b0);
        doCheck("and_f0_3c",   3'b100, 8'hF0,  8'h3C,  1, 8'h30,  1'b0, 1'b0, 1'b0);
        doCheck("or_f0_3c",    3'b101, 8'hF0,  8'h3C,  1, 8'hFC,  1'b0, 1'b0, 1'b0);

        // Multiply
        doCheck("mul_20_15",   3'b110, 8'd20,  8'd15,  9, 8'd44,  1'b1, 1'b0, 1'b0);
        doCheck("mul_12_10",   3'b110, 8'd12,  8'd10,  9, 8'd120, 1'b0, 1'b0, 1'b0);
        doCheck("mul_ff_ff",   3'b110, 8'd255, 8'd255, 9, 8'd1,   1'b1, 1'b0, 1'b0);
        doCheck("mul_0_77",    3'b110, 8'd0,   8'd77,  9, 8'd0,   1'b0, 1'b1, 1'b0);

        // Modulo
        doCheck("mod_200_7",   3'b111, 8'd200, 8'd7,   9, 8'd4,   1'b0, 1'b0, 1'b0);
        doCheck("mod_7_200",   3'b111, 8'd7,   8'd200, 9, 8'd7,   1'b0, 1'b0, 1'b0);
        doCheck("mod_255_16",  3'b111, 8'd255, 8'd16,  9, 8'd15,  1'b0, 1'b0, 1'b0);
        doCheck("mod_14_7",    3'b111, 8'd14,  8'd7,   9, 8'd0,   1'b0, 1'b1, 1'b0);
        doCheck("mod_200_0",   3'b111, 8'd200, 8'd0,   1, 8'd200, 1'b0, 1'b0, 1'b1);
        doCheck("mod_0_0",     3'b111, 8'd0,   8'd0,   1, 8'd0,   1'b0, 1'b1, 1'b1);

        // out_ready while idle has no effect
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkVal("idle_ready_valid", bus.out_valid, 0);
        checkVal("idle_ready_in_ready", bus.in_ready, 1);

        // Backpressure: hold result for 5 cycles while a new request is offered
        runOp(3'b110, 8'd20, 8'd15, lat);
        checkVal("bp_lat", lat, 9);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 3'b010;
            bus.a = 8'd1;
            bus.b = 8'd1;
            @(posedge clk); #1;
            checkVal($sformatf("bp_valid_%0d", i), bus.out_valid, 1);
            checkVal($sformatf("bp_in_ready_%0d", i), bus.in_ready, 0);
            checkVal($sformatf("bp_res_%0d", i), bus.result, 8'd44);
            checkVal($sformatf("bp_carry_%0d", i), bus.carry, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        checkVal("bp_release_in_ready", bus.in_ready, 1);
        checkVal("bp_release_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        checkVal("bp_no_accept", bus.out_valid, 0);

        // Reset in cycle 4 of a multiply aborts it
        bus.in_valid = 1'b1;
        bus.op = 3'b110;
        bus.a = 8'd20;
        bus.b = 8'd15;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        checkVal("busy_in_ready", bus.in_ready, 0);
        checkVal("busy_result_held", bus.result, 8'd44);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkVal("abort_valid", bus.out_valid, 0);
        checkVal("abort_result", bus.result, 0);
        checkVal("abort_carry", bus.carry, 0);
        checkVal("abort_zero", bus.zero, 0);
        checkVal("abort_err", bus.err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checkVal("abort_no_valid", seen, 0);
        doCheck("and_after_rst", 3'b100, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0, 1'b0);

        // MUL disabled instance
        noMulOp("nomul_add", 3'b010, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
        noMulOp("nomul_mul", 3'b110, 8'd3, 8'd4, 8'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, legal range 4..32.
REQ-002 Parameter MUL_EN, default 1; 1 = MUL opcode implemented, 0 = MUL treated as illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts a new operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  opcode: 000 -A, 001 -B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A*B, 111 A mod B.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry  output  1  adder carry-out / multiply overflow.
REQ-014 zero  output  1  result == 0.
REQ-015 err  output  1  divide-by-zero or illegal opcode.

Function
REQ-016 States IDLE, BUSY, DONE, held in a registered state machine.
REQ-017 in_ready SHALL be 1 only in IDLE; transfer occurs on a cycle with in_valid & in_ready.
REQ-018 a, b, op SHALL be registered at transfer; later input changes do not affect the operation.
REQ-019 Ops 000-101: IDLE -> DONE on transfer; out_valid asserted the next cycle (latency 1).
REQ-020 Arithmetic modulo 2^WIDTH, two's complement: -A = ~A+1, A-B = A+~B+1; carry = adder carry-out (1 for A-B when A>=B unsigned, 1 for -A only when A==0).
REQ-021 AND/OR bitwise over all WIDTH bits; carry = 0.
REQ-022 MUL: unsigned shift-add, one partial product per cycle; IDLE -> BUSY -> DONE; out_valid asserted exactly WIDTH+1 cycles after transfer; result = low WIDTH bits of product; carry = 1 iff high WIDTH bits nonzero.
REQ-023 MOD: unsigned restoring division, one quotient bit per cycle; out_valid exactly WIDTH+1 cycles after transfer; result = A mod B; carry = 0.
REQ-024 MOD with B == 0: no BUSY phase; DONE after 1 cycle, result = A, err = 1.
REQ-025 MUL with MUL_EN = 0: latency 1, result = 0, carry = 0, err = 1.
REQ-026 err = 0 for all other cases; zero computed from final result for every op.
REQ-027 DONE: result, carry, zero, err held stable while out_valid & !out_ready.
REQ-028 DONE -> IDLE on out_ready; in_ready rises the cycle after out_valid & out_ready; no new operation accepted in the handshake cycle itself.
REQ-029 out_ready asserted in IDLE or BUSY has no effect.
REQ-030 BUSY ignores in_valid; in_ready = 0 throughout.
REQ-031 Iteration counter width ceil(log2(WIDTH+1)); counter terminates exactly at WIDTH steps, no wrap-around beyond.

Reset
REQ-032 reset = 1 SHALL immediately force state IDLE, in_ready = 1 (once reset deasserts), out_valid = 0, result = 0, carry = 0, zero = 0, err = 0, internal accumulators and counter = 0.
REQ-033 reset during BUSY or DONE SHALL abort the operation; no out_valid for it is ever produced.
REQ-034 in_valid during reset is ignored; first acceptable transfer is on the first rising edge with reset = 0.

Verification
REQ-035 WIDTH=8: op=010, a=200, b=100, out_ready=1 -> out_valid next cycle, result=44, carry=1, zero=0, err=0.
REQ-036 WIDTH=8: op=011, a=5, b=5 -> result=0, carry=1, zero=1; op=000, a=1 -> result=255, carry=0.
REQ-037 WIDTH=8: op=110, a=20, b=15 -> out_valid exactly 9 cycles after transfer, result=44, carry=1; a=12, b=10 -> result=120, carry=0.
REQ-038 WIDTH=8: op=111, a=200, b=7 -> out_valid 9 cycles after transfer, result=4; b=0 -> out_valid after 1 cycle, result=200, err=1.
REQ-039 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-040 Reset mid-MUL (cycle 4 of 9) -> all outputs 0 immediately, no out_valid; subsequent op=100, a=0xF0, b=0x3C -> result=0x30.
